execute_stage_md: RTL and testbench
===================================

Name: execute_stage_md

Overview:
- Parametrised successor to the existing 32-bit execute stage. Adds RV32M multiply/divide execution, a valid/flush pipeline protocol and a stall output to the hazard unit.
- Keeps the existing structure: 3:1 forwarding muxes, ALU-source mux, ALU, branch-target adder, and the EX/MEM pipeline register.
- Sits between the ID/EX register and the memory stage.
- Multi-cycle M-ops hold the front of the pipe via stall_e and insert bubbles into M.

Parameters:
- XLEN, 32, datapath width (even, ≥8).
- REGW, 5, register index width.
- CTRLMW, 4, width of control bits forwarded to M/W.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- valid_e  in  1  EX holds a real instruction.
- flush_e  in  1  kill the EX instruction, including any in-flight M-op.
- rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e  in  XLEN  ID/EX operands.
- alu_result_mh, result_w  in  XLEN  forwarding sources from M and W.
- forward_a_e, forward_b_e  in  2  forwarding select: 00 = reg, 01 = W, 10 = M.
- rd_e  in  REGW  destination register.
- funct3_e  in  3  sub-op.
- alu_src_e  in  1  1 = immediate as source B.
- alu_ctrl_e  in  4  ALU op, existing encoding.
- md_e  in  1  instruction is an M-extension op.
- branch_e, jump_e  in  1  control-flow class.
- ctrl_m_e  in  CTRLMW  control forwarded to M.
- pc_target_e  out  XLEN  pc_e + imm_ext_e.
- pc_src_e  out  1  redirect fetch (taken branch or jump, valid_e only).
- alu_result_e  out  XLEN  combinational ALU result.
- stall_e  out  1  hold IF/ID/EX.
- alu_result_m, write_data_m, pc_plus4_m  out  XLEN  EX/MEM register.
- rd_m  out  REGW  EX/MEM register.
- ctrl_m  out  CTRLMW  EX/MEM register.
- valid_m  out  1  EX/MEM register.

Behaviour:
- Reset: all EX/MEM outputs 0, FSM to IDLE, stall_e = 0. Reset is asynchronous and applies mid-operation.
- Source A = fwd mux(forward_a_e). src_b_raw = fwd mux(forward_b_e). Source B = alu_src_e ? imm_ext_e : src_b_raw.
- write_data_m captures src_b_raw.
- Branch condition by funct3: BEQ/BNE/BLT/BGE/BLTU/BGEU from the ALU zero/sign/less-than flags.
- Non-M instruction: 1-cycle latency, as in the existing stage.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL when valid_e & md_e & funct3 < 4 & !flush_e.
  - IDLE → DIV when valid_e & md_e & funct3 ≥ 4 & !flush_e.
  - Entering MUL/DIV latches source A, source B, funct3, rd_e, ctrl_m_e and pc_plus4_e. Upstream forwarding may change while busy and must not affect the result.
- MUL: shift-add, one bit per cycle, XLEN cycles.
  - Operands are sign- or magnitude-converted per MUL/MULH/MULHSU/MULHU; the sign is fixed up at the end.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- DIV: restoring, one quotient bit per cycle, XLEN cycles.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Divide by zero: quotient = all ones, remainder = dividend. Both skip iteration and go to DONE next cycle.
  - Signed overflow (MIN / −1): quotient = MIN, remainder = 0, same early exit.
- DONE lasts 1 cycle and returns to IDLE.
  - The EX/MEM register loads the result with valid_m = 1.
  - stall_e drops in this cycle, so the next instruction enters EX the following cycle.
- stall_e = 1 in the accept cycle and in every MUL/DIV cycle.
  - Total M-op latency = XLEN + 2 cycles from accept to valid_m.
- While stall_e = 1 and not in DONE: the EX/MEM register loads a bubble (valid_m = 0, ctrl_m = 0, other fields unchanged).
- flush_e:
  - In IDLE: EX/MEM loads a bubble.
  - In MUL/DIV/DONE: abort to IDLE next cycle and load a bubble; stall_e deasserts the same cycle.
  - flush_e has priority over DONE.
- pc_src_e is masked by valid_e & !flush_e. Branches never coincide with an M-op accept, because stall_e holds them in ID.

Optional Feature:
- Macro: EXEC_FAST_MUL_EN.
- Defined: MUL* ops use a combinational XLEN×XLEN multiplier with 1-cycle latency, no stall, and never enter the MUL state.
- Undefined: the iterative MUL path above is used. Division is always iterative.

Decomposition:
- Shared package exec_pkg holds:
  - ALU op codes.
  - funct3 constants for branches and M-ops.
  - Forward-select constants (FWD_REG/FWD_W/FWD_M).
  - md_state_t enum.
- Natural sub-module: md_unit. It contains the FSM, iterative mul/div, and start/done/busy signals.
- Existing ALU, Adder and multiplexers are reused, widened to XLEN.

Test Plan:
- ADD with forward_a_e = 10, alu_result_mh = 5, rd2_e = 7 → next cycle alu_result_m = 12, valid_m = 1, stall_e never asserted.
- MUL 0xFFFFFFFF × 3 (signed) → stall_e high 33 cycles, valid_m = 0 during them; at DONE alu_result_m = 0xFFFFFFFD. MULH of the same operands → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000. REM of the same → 0. DIVU 7/0 → 0xFFFFFFFF. REMU 7/0 → 7. Each completes 2 cycles after accept.
- DIV 100 / 7 with forwarding sources changed every busy cycle → quotient 14 (REM → 2); result unaffected by the changes.
- flush_e asserted mid-DIV → returns to IDLE, stall_e low next cycle, no valid_m pulse for the aborted op.
- RST_N pulsed low mid-MUL → all outputs 0 immediately (asynchronous), FSM IDLE, a subsequent ADD completes normally.

Source files
------------

// File: rtl/exec_pkg.sv
//------------------------------------------------------------------------------
// Module   : exec_pkg
// Brief    : Shared constants and types for the RV32M-capable execute stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/execute_stage_md_if.sv
//------------------------------------------------------------------------------
// Module   : execute_stage_md_if
// Brief    : ID/EX operand bus and EX/MEM result bus of the execute stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface execute_stage_md_if #(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter int CTRLMW = 4
);
    logic              valid_e;
    logic              flush_e;
    logic [XLEN-1:0]   rd1_e;
    logic [XLEN-1:0]   rd2_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   imm_ext_e;
    logic [XLEN-1:0]   pc_plus4_e;
    logic [XLEN-1:0]   alu_result_mh;
    logic [XLEN-1:0]   result_w;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic [REGW-1:0]   rd_e;
    logic [2:0]        funct3_e;
    logic              alu_src_e;
    logic [3:0]        alu_ctrl_e;
    logic              md_e;
    logic              branch_e;
    logic              jump_e;
    logic [CTRLMW-1:0] ctrl_m_e;

    logic [XLEN-1:0]   pc_target_e;
    logic              pc_src_e;
    logic [XLEN-1:0]   alu_result_e;
    logic              stall_e;
    logic [XLEN-1:0]   alu_result_m;
    logic [XLEN-1:0]   write_data_m;
    logic [XLEN-1:0]   pc_plus4_m;
    logic [REGW-1:0]   rd_m;
    logic [CTRLMW-1:0] ctrl_m;
    logic              valid_m;

    modport master (
        output valid_e, flush_e, rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e,
               alu_result_mh, result_w, forward_a_e, forward_b_e, rd_e, funct3_e,
               alu_src_e, alu_ctrl_e, md_e, branch_e, jump_e, ctrl_m_e,
        input  pc_target_e, pc_src_e, alu_result_e, stall_e, alu_result_m,
               write_data_m, pc_plus4_m, rd_m, ctrl_m, valid_m
    );

    modport slave (
        input  valid_e, flush_e, rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e,
               alu_result_mh, result_w, forward_a_e, forward_b_e, rd_e, funct3_e,
               alu_src_e, alu_ctrl_e, md_e, branch_e, jump_e, ctrl_m_e,
        output pc_target_e, pc_src_e, alu_result_e, stall_e, alu_result_m,
               write_data_m, pc_plus4_m, rd_m, ctrl_m, valid_m
    );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
//------------------------------------------------------------------------------
// Module   : md_unit
// Brief    : Iterative RV32M multiply (shift-add) / divide (restoring) engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_unit
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter int CTRLMW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   pc_plus4_i,
    input  logic [REGW-1:0]   rd_i,
    input  logic [CTRLMW-1:0] ctrl_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   pc_plus4_o,
    output logic [REGW-1:0]   rd_o,
    output logic [CTRLMW-1:0] ctrl_o
);
    localparam int              CW    = $clog2(XLEN);
    localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t           state_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opb_q, res_q, wdata_q, pc4_q;
    logic [2:0]          f3_q;
    logic [REGW-1:0]     rd_q;
    logic [CTRLMW-1:0]   ctrl_q;
    logic                neg_q, negr_q, special_q;
    logic [CW-1:0]       cnt_q;

    logic                w_a_sgn, w_b_sgn, w_div0, w_ovf;
    logic [XLEN-1:0]     w_a_mag, w_b_mag, w_special;

    // Operands become magnitudes at accept; signs are re-applied on the final step.
    always_comb begin
        w_a_sgn   = a_i[XLEN-1] & (funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
        w_b_sgn   = b_i[XLEN-1] & (funct3_i inside {F3_MULH, F3_DIV, F3_REM});
        w_a_mag   = w_a_sgn ? -a_i : a_i;
        w_b_mag   = w_b_sgn ? -b_i : b_i;
        w_div0    = funct3_i[2] && (b_i == '0);
        w_ovf     = (funct3_i == F3_DIV || funct3_i == F3_REM) && (a_i == C_MIN) && (b_i == '1);
        if (w_div0) w_special = funct3_i[1] ? a_i : '1;
        else        w_special = funct3_i[1] ? '0 : C_MIN;
    end

    logic [XLEN:0]       w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0]   w_step, w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_fix;

    // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        w_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        w_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_diff  = w_shift - {1'b0, opb_q};
        if (state_q == MD_MUL) w_step = {w_sum, acc_q[XLEN-1:1]};
        else if (w_diff[XLEN]) w_step = {w_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else                   w_step = {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        w_prod = neg_q  ? -w_step : w_step;
        w_quo  = neg_q  ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
        w_rem  = negr_q ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
        if (state_q == MD_MUL) w_fix = (f3_q == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        else                   w_fix = f3_q[1] ? w_rem : w_quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            acc_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            wdata_q   <= '0;
            pc4_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            neg_q     <= 1'b0;
            negr_q    <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        state_q   <= funct3_i[2] ? MD_DIV : MD_MUL;
                        acc_q     <= {{XLEN{1'b0}}, w_a_mag};
                        opb_q     <= w_b_mag;
                        res_q     <= w_special;
                        wdata_q   <= wdata_i;
                        pc4_q     <= pc_plus4_i;
                        f3_q      <= funct3_i;
                        rd_q      <= rd_i;
                        ctrl_q    <= ctrl_i;
                        neg_q     <= w_a_sgn ^ w_b_sgn;
                        negr_q    <= w_a_sgn;
                        special_q <= w_div0 | w_ovf;
                        cnt_q     <= '0;
                    end
                end
                MD_MUL, MD_DIV: begin
                    if (flush_i) begin
                        state_q <= MD_IDLE;
                    end else if (special_q) begin
                        state_q <= MD_DONE;
                    end else begin
                        acc_q <= w_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN-1)) begin
                            state_q <= MD_DONE;
                            res_q   <= w_fix;
                        end
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign stall_o    = ((state_q == MD_IDLE) && start_i) ||
                        (((state_q == MD_MUL) || (state_q == MD_DIV)) && !flush_i);
    assign done_o     = (state_q == MD_DONE);
    assign result_o   = res_q;
    assign wdata_o    = wdata_q;
    assign pc_plus4_o = pc4_q;
    assign rd_o       = rd_q;
    assign ctrl_o     = ctrl_q;

endmodule

`default_nettype wire

// File: rtl/execute_stage_md.sv
//------------------------------------------------------------------------------
// Module   : execute_stage_md
// Brief    : RV32IM execute stage with forwarding, ALU, branch resolution,
//            iterative mul/div and the EX/MEM pipeline register.
//            Define EXEC_FAST_MUL_EN for a single-cycle combinational multiplier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module execute_stage_md
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter int CTRLMW = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    execute_stage_md_if.slave    ex
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_src_a, w_src_b_raw, w_src_b, w_alu_result;
    logic [XLEN:0]   w_diff;
    logic            w_zero, w_lt, w_ltu, w_taken;

    always_comb begin
        unique case (ex.forward_a_e)
            FWD_W:   w_src_a = ex.result_w;
            FWD_M:   w_src_a = ex.alu_result_mh;
            default: w_src_a = ex.rd1_e;
        endcase
        unique case (ex.forward_b_e)
            FWD_W:   w_src_b_raw = ex.result_w;
            FWD_M:   w_src_b_raw = ex.alu_result_mh;
            default: w_src_b_raw = ex.rd2_e;
        endcase
        w_src_b = ex.alu_src_e ? ex.imm_ext_e : w_src_b_raw;
    end

    // Flags come from a dedicated subtractor so branches resolve regardless of alu_ctrl.
    always_comb begin
        w_diff = {1'b0, w_src_a} - {1'b0, w_src_b};
        w_zero = (w_diff[XLEN-1:0] == '0);
        w_ltu  = w_diff[XLEN];
        w_lt   = (w_src_a[XLEN-1] != w_src_b[XLEN-1]) ? w_src_a[XLEN-1] : w_diff[XLEN-1];
        unique case (ex.alu_ctrl_e)
            ALU_SUB:  w_alu_result = w_diff[XLEN-1:0];
            ALU_AND:  w_alu_result = w_src_a & w_src_b;
            ALU_OR:   w_alu_result = w_src_a | w_src_b;
            ALU_XOR:  w_alu_result = w_src_a ^ w_src_b;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, w_ltu};
            ALU_SLL:  w_alu_result = w_src_a << w_src_b[SHW-1:0];
            ALU_SRL:  w_alu_result = w_src_a >> w_src_b[SHW-1:0];
            ALU_SRA:  w_alu_result = $signed(w_src_a) >>> w_src_b[SHW-1:0];
            default:  w_alu_result = w_src_a + w_src_b;
        endcase
        unique case (ex.funct3_e)
            F3_BEQ:  w_taken = w_zero;
            F3_BNE:  w_taken = !w_zero;
            F3_BLT:  w_taken = w_lt;
            F3_BGE:  w_taken = !w_lt;
            F3_BLTU: w_taken = w_ltu;
            F3_BGEU: w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    assign ex.pc_target_e  = ex.pc_e + ex.imm_ext_e;
    assign ex.pc_src_e     = ex.valid_e && !ex.flush_e && (ex.jump_e || (ex.branch_e && w_taken));
    assign ex.alu_result_e = w_alu_result;

    logic            w_fast_mul;
    logic [XLEN-1:0] w_fast_res;
`ifdef EXEC_FAST_MUL_EN
    logic              w_fa_s, w_fb_s;
    logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
    assign w_fast_mul = ex.valid_e && ex.md_e && !ex.funct3_e[2];
    assign w_fa_s     = w_src_a[XLEN-1] && (ex.funct3_e == F3_MULH || ex.funct3_e == F3_MULHSU);
    assign w_fb_s     = w_src_b[XLEN-1] && (ex.funct3_e == F3_MULH);
    assign w_fa       = {{XLEN{w_fa_s}}, w_src_a};
    assign w_fb       = {{XLEN{w_fb_s}}, w_src_b};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast_res = (ex.funct3_e == F3_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast_mul = 1'b0;
    assign w_fast_res = '0;
`endif

    logic              w_md_start, w_stall, w_md_done;
    logic [XLEN-1:0]   w_md_result, w_md_wdata, w_md_pc4;
    logic [REGW-1:0]   w_md_rd;
    logic [CTRLMW-1:0] w_md_ctrl;

    assign w_md_start = ex.valid_e && ex.md_e && !ex.flush_e && !w_fast_mul;

    md_unit #(
        .XLEN   (XLEN),
        .REGW   (REGW),
        .CTRLMW (CTRLMW)
    ) u_md_unit (
        .clk        (CLK),
        .rst_n      (RST_N),
        .start_i    (w_md_start),
        .flush_i    (ex.flush_e),
        .funct3_i   (ex.funct3_e),
        .a_i        (w_src_a),
        .b_i        (w_src_b),
        .wdata_i    (w_src_b_raw),
        .pc_plus4_i (ex.pc_plus4_e),
        .rd_i       (ex.rd_e),
        .ctrl_i     (ex.ctrl_m_e),
        .stall_o    (w_stall),
        .done_o     (w_md_done),
        .result_o   (w_md_result),
        .wdata_o    (w_md_wdata),
        .pc_plus4_o (w_md_pc4),
        .rd_o       (w_md_rd),
        .ctrl_o     (w_md_ctrl)
    );

    assign ex.stall_e = w_stall;

    logic [XLEN-1:0]   alu_result_m_q, alu_result_m_d, write_data_m_q, write_data_m_d;
    logic [XLEN-1:0]   pc_plus4_m_q, pc_plus4_m_d;
    logic [REGW-1:0]   rd_m_q, rd_m_d;
    logic [CTRLMW-1:0] ctrl_m_q, ctrl_m_d;
    logic              valid_m_q, valid_m_d;

    // Bubbles clear only valid/ctrl; flush outranks a finishing M-op.
    always_comb begin
        alu_result_m_d = alu_result_m_q;
        write_data_m_d = write_data_m_q;
        pc_plus4_m_d   = pc_plus4_m_q;
        rd_m_d         = rd_m_q;
        ctrl_m_d       = '0;
        valid_m_d      = 1'b0;
        if (ex.flush_e || w_stall) begin
            ctrl_m_d = '0;
        end else if (w_md_done) begin
            alu_result_m_d = w_md_result;
            write_data_m_d = w_md_wdata;
            pc_plus4_m_d   = w_md_pc4;
            rd_m_d         = w_md_rd;
            ctrl_m_d       = w_md_ctrl;
            valid_m_d      = 1'b1;
        end else begin
            alu_result_m_d = w_fast_mul ? w_fast_res : w_alu_result;
            write_data_m_d = w_src_b_raw;
            pc_plus4_m_d   = ex.pc_plus4_e;
            rd_m_d         = ex.rd_e;
            ctrl_m_d       = ex.valid_e ? ex.ctrl_m_e : '0;
            valid_m_d      = ex.valid_e;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= '0;
            ctrl_m_q       <= '0;
            valid_m_q      <= 1'b0;
        end else begin
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
            rd_m_q         <= rd_m_d;
            ctrl_m_q       <= ctrl_m_d;
            valid_m_q      <= valid_m_d;
        end
    end

    assign ex.alu_result_m = alu_result_m_q;
    assign ex.write_data_m = write_data_m_q;
    assign ex.pc_plus4_m   = pc_plus4_m_q;
    assign ex.rd_m         = rd_m_q;
    assign ex.ctrl_m       = ctrl_m_q;
    assign ex.valid_m      = valid_m_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage_md.sv
//------------------------------------------------------------------------------
// Module   : tb_execute_stage_md
// Brief    : Directed self-checking bench for execute_stage_md (default build).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_execute_stage_md;
    import exec_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    execute_stage_md_if #(.XLEN(32), .REGW(5), .CTRLMW(4)) bus ();

    execute_stage_md #(.XLEN(32), .REGW(5), .CTRLMW(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .ex    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_e = 0; bus.flush_e = 0; bus.rd1_e = '0; bus.rd2_e = '0;
        bus.pc_e = '0; bus.imm_ext_e = '0; bus.pc_plus4_e = '0;
        bus.alu_result_mh = '0; bus.result_w = '0;
        bus.forward_a_e = FWD_REG; bus.forward_b_e = FWD_REG;
        bus.rd_e = '0; bus.funct3_e = '0; bus.alu_src_e = 0; bus.alu_ctrl_e = ALU_ADD;
        bus.md_e = 0; bus.branch_e = 0; bus.jump_e = 0; bus.ctrl_m_e = '0;
    endtask

    // Issues one M-op, counts stalled cycles, then checks the DONE write-back.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_stall, input bit perturb);
        int cnt = 0;
        bit bubble_ok = 1'b1;
        idle_inputs();
        bus.valid_e = 1; bus.md_e = 1; bus.funct3_e = f3;
        bus.rd1_e = a; bus.rd2_e = b; bus.rd_e = 5'd9; bus.ctrl_m_e = 4'h5;
        bus.pc_plus4_e = 32'h0000_0104;
        #1;
        while (bus.stall_e && cnt < 100) begin
            tick();
            cnt++;
            if (bus.valid_m !== 1'b0) bubble_ok = 1'b0;
            if (perturb) begin
                bus.alu_result_mh = $urandom;
                bus.result_w      = $urandom;
                bus.forward_a_e   = 2'($urandom_range(0, 2));
                bus.forward_b_e   = 2'($urandom_range(0, 2));
            end
        end
        chk({tag, " stall cycles"}, cnt, exp_stall);
        chk({tag, " bubbles while busy"}, {31'd0, bubble_ok}, 32'd1);
        tick();
        chk({tag, " valid_m"}, {31'd0, bus.valid_m}, 32'd1);
        chk({tag, " result"}, bus.alu_result_m, exp);
        chk({tag, " rd_m"}, {27'd0, bus.rd_m}, 32'd9);
        idle_inputs();
    endtask

    initial begin
        bit pulse_seen;
        idle_inputs();
        #12;
        chk("reset valid_m", {31'd0, bus.valid_m}, 32'd0);
        chk("reset alu_result_m", bus.alu_result_m, 32'd0);
        chk("reset stall_e", {31'd0, bus.stall_e}, 32'd0);
        chk("reset ctrl_m", {28'd0, bus.ctrl_m}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // ADD with M-stage forwarding on A
        bus.valid_e = 1; bus.forward_a_e = FWD_M; bus.alu_result_mh = 32'd5; bus.rd2_e = 32'd7;
        bus.alu_ctrl_e = ALU_ADD; bus.rd_e = 5'd3; bus.ctrl_m_e = 4'hA; bus.pc_plus4_e = 32'h14;
        #1;
        chk("add comb", bus.alu_result_e, 32'd12);
        chk("add stall", {31'd0, bus.stall_e}, 32'd0);
        tick();
        chk("add result_m", bus.alu_result_m, 32'd12);
        chk("add valid_m", {31'd0, bus.valid_m}, 32'd1);
        chk("add rd_m", {27'd0, bus.rd_m}, 32'd3);
        chk("add ctrl_m", {28'd0, bus.ctrl_m}, 32'hA);
        chk("add write_data_m", bus.write_data_m, 32'd7);
        chk("add pc_plus4_m", bus.pc_plus4_m, 32'h14);
        chk("add stall after", {31'd0, bus.stall_e}, 32'd0);
        idle_inputs();
        tick();
        chk("idle valid_m", {31'd0, bus.valid_m}, 32'd0);

        // Branch resolution
        bus.valid_e = 1; bus.branch_e = 1; bus.alu_ctrl_e = ALU_SUB; bus.pc_e = 32'h100;
        bus.imm_ext_e = 32'h20; bus.rd1_e = 32'd5; bus.rd2_e = 32'd5; bus.funct3_e = F3_BEQ;
        #1;
        chk("beq taken", {31'd0, bus.pc_src_e}, 32'd1);
        chk("pc_target", bus.pc_target_e, 32'h120);
        bus.funct3_e = F3_BLT; bus.rd1_e = 32'hFFFF_FFFF; bus.rd2_e = 32'd1; #1;
        chk("blt taken", {31'd0, bus.pc_src_e}, 32'd1);
        bus.funct3_e = F3_BLTU; #1;
        chk("bltu not taken", {31'd0, bus.pc_src_e}, 32'd0);
        bus.funct3_e = F3_BLT; bus.flush_e = 1; #1;
        chk("blt flushed", {31'd0, bus.pc_src_e}, 32'd0);
        idle_inputs();
        tick();

        run_md("mul", F3_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33, 1'b0);
        run_md("mulh", F3_MULH, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 33, 1'b0);
        run_md("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 33, 1'b0);
        run_md("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
        run_md("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
        run_md("divu by 0", F3_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        run_md("remu by 0", F3_REMU, 32'd7, 32'd0, 32'd7, 2, 1'b0);
        run_md("div 100/7", F3_DIV, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        run_md("rem 100/7", F3_REM, 32'd100, 32'd7, 32'd2, 33, 1'b1);
        run_md("div -100/7", F3_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
        run_md("rem -100/7", F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);

        // Flush while dividing
        bus.valid_e = 1; bus.md_e = 1; bus.funct3_e = F3_DIV; bus.rd1_e = 32'd100; bus.rd2_e = 32'd7;
        #1;
        repeat (5) tick();
        chk("flush pre stall", {31'd0, bus.stall_e}, 32'd1);
        bus.flush_e = 1; #1;
        chk("flush stall same cycle", {31'd0, bus.stall_e}, 32'd0);
        tick();
        idle_inputs(); #1;
        chk("flush stall next", {31'd0, bus.stall_e}, 32'd0);
        chk("flush valid_m", {31'd0, bus.valid_m}, 32'd0);
        pulse_seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.valid_m !== 1'b0) pulse_seen = 1'b1;
        end
        chk("flush no valid pulse", {31'd0, pulse_seen}, 32'd0);

        // Asynchronous reset in the middle of a multiply
        bus.valid_e = 1; bus.md_e = 1; bus.funct3_e = F3_MUL; bus.rd1_e = 32'd3; bus.rd2_e = 32'd5;
        bus.rd_e = 5'd7; bus.pc_plus4_e = 32'h200;
        #1;
        repeat (10) tick();
        #2;
        idle_inputs();
        rst_n = 0;
        #1;
        chk("async rst alu_result_m", bus.alu_result_m, 32'd0);
        chk("async rst pc_plus4_m", bus.pc_plus4_m, 32'd0);
        chk("async rst stall_e", {31'd0, bus.stall_e}, 32'd0);
        #3;
        rst_n = 1;
        tick();
        bus.valid_e = 1; bus.forward_b_e = FWD_W; bus.result_w = 32'h10; bus.rd1_e = 32'h22;
        bus.alu_ctrl_e = ALU_ADD; bus.rd_e = 5'd4;
        #1;
        tick();
        chk("post-reset add", bus.alu_result_m, 32'h32);
        chk("post-reset add valid", {31'd0, bus.valid_m}, 32'd1);
        idle_inputs();
        tick();
        run_md("post-reset mul", F3_MUL, 32'd3, 32'd5, 32'd15, 33, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
